// File: rtl/alu_seq_param_pkg.sv
// ---------------------------------------------------------------------------
// alu_package
// Shared types and helpers for the sequential signed ALU (alu_seq_param) and
// its shift-add multiplier (alu_mul_seq).
//   opcode_e : 3-bit operation select
//   state_e  : top-level FSM states (IDLE, MUL, DONE)
//   sat_w()  : clamp a signed 64-bit value to a w-bit signed range
// ---------------------------------------------------------------------------
package alu_package;

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_AND = 3'b010,
        OP_OR  = 3'b011,
        OP_XOR = 3'b100,
        OP_MUL = 3'b101,
        OP_NOT = 3'b110,
        OP_ILL = 3'b111
    } opcode_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_MUL  = 2'b01,
        ST_DONE = 2'b10
    } state_e;

    // Saturate a signed value (carried in 64 bits) to [-2^(w-1), 2^(w-1)-1].
    // Callers sign-extend into 64 bits and slice the result back down, which
    // keeps the helper independent of the ALU width parameter (w <= 63).
    function automatic logic [63:0] sat_w(input logic [63:0] v, input int w);
        logic signed [63:0] sv;
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        sv = $signed(v);
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (w - 1));
        if (sv > hi) begin
            return hi;
        end else if (sv < lo) begin
            return lo;
        end else begin
            return sv;
        end
    endfunction

endpackage

// File: rtl/alu_seq_param_mul_seq.sv
// ---------------------------------------------------------------------------
// alu_mul_seq
// Sequential signed multiplier: magnitudes are multiplied by shift-add, one
// partial product per enabled cycle, and the sign is applied on the output.
// A start pulse loads the operands; WIDTH iterations follow; o_done pulses
// for one enabled cycle once the product is final and stays valid afterwards.
// Ports:
//   clk        in   clock, rising edge
//   rst        in   asynchronous active-low reset
//   i_en       in   global enable; 0 freezes every register
//   i_start    in   load operands and begin (ignored unless i_en)
//   i_a, i_b   in   WIDTH-bit signed operands
//   o_busy     out  iterations in progress
//   o_done     out  product final (one enabled-cycle pulse)
//   o_product  out  2*WIDTH-bit signed product
// ---------------------------------------------------------------------------
module alu_mul_seq #(
    parameter int WIDTH = 4,
    localparam int RES_W = 2 * WIDTH,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_en,
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic             o_busy,
    output logic             o_done,
    output logic [RES_W-1:0] o_product
);

    logic [RES_W-1:0] r_acc;
    logic [RES_W-1:0] r_mcand;
    logic [WIDTH-1:0] r_mplier;
    logic [CNT_W-1:0] r_cnt;
    logic             r_neg;
    logic             r_busy;
    logic             r_done;

    // |x| as WIDTH-bit unsigned: the most negative value maps to 2^(WIDTH-1),
    // which still fits, so no extra bit is needed.
    logic [WIDTH-1:0] w_abs_a;
    logic [WIDTH-1:0] w_abs_b;

    assign w_abs_a = i_a[WIDTH-1] ? (~i_a + 1'b1) : i_a;
    assign w_abs_b = i_b[WIDTH-1] ? (~i_b + 1'b1) : i_b;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_cnt    <= '0;
            r_neg    <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else if (i_en) begin
            r_done <= 1'b0;
            if (i_start) begin
                r_acc    <= '0;
                r_mcand  <= {{(RES_W-WIDTH){1'b0}}, w_abs_a};
                r_mplier <= w_abs_b;
                r_neg    <= i_a[WIDTH-1] ^ i_b[WIDTH-1];
                r_cnt    <= '0;
                r_busy   <= 1'b1;
            end else if (r_busy) begin
                if (r_mplier[0]) begin
                    r_acc <= r_acc + r_mcand;
                end
                r_mcand  <= r_mcand << 1;
                r_mplier <= r_mplier >> 1;
                r_cnt    <= r_cnt + 1'b1;
                if (r_cnt == CNT_W'(WIDTH - 1)) begin
                    r_busy <= 1'b0;
                    r_done <= 1'b1;
                end
            end
        end
    end

    assign o_busy    = r_busy;
    assign o_done    = r_done;
    assign o_product = r_neg ? (~r_acc + 1'b1) : r_acc;

endmodule

// File: rtl/alu_seq_param.sv
// ---------------------------------------------------------------------------
// alu_seq_param
// Sequential signed ALU with valid/ready handshakes on input and output.
// Single-cycle ADD/SUB/AND/OR/XOR/NOT, multi-cycle MUL via alu_mul_seq,
// illegal opcode flagged on err.
// Optional feature macro: ALU_SAT_EN -- when defined, ADD/SUB saturate to
// the WIDTH-bit signed range (then sign-extended); otherwise they return the
// exact WIDTH+1-bit result sign-extended to RES_W.
// Handshake: a transfer happens on a rising edge where valid & ready are both
// high (and en=1); ready never depends on valid, in_ready may depend
// combinationally on out_ready, and C/err stay stable while out_valid is high
// and out_ready is low.
// Ports:
//   clk        in   clock, rising edge
//   rst        in   asynchronous active-low reset
//   en         in   global enable; 0 freezes all state, in_ready=0
//   A, B       in   WIDTH-bit signed operands
//   opcode     in   3-bit operation select (opcode_e)
//   in_valid   in   operands valid
//   in_ready   out  operands accepted this cycle
//   C          out  RES_W-bit signed registered result
//   err        out  result came from an illegal opcode
//   out_valid  out  C/err valid
//   out_ready  in   consumer accepts result
// ---------------------------------------------------------------------------
module alu_seq_param
    import alu_package::*;
#(
    parameter int WIDTH = 4,
    localparam int RES_W = 2 * WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [2:0]       opcode,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [RES_W-1:0] C,
    output logic             err,
    output logic             out_valid,
    input  logic             out_ready
);

    state_e           r_state;
    state_e           w_state_nxt;
    logic [RES_W-1:0] r_c;
    logic             r_err;

    opcode_e          w_op;
    logic             w_accept;
    logic             w_mul_start;
    logic             w_mul_busy;
    logic             w_mul_done;
    logic [RES_W-1:0] w_mul_product;

    logic [RES_W-1:0] w_a_ext;
    logic [RES_W-1:0] w_b_ext;
    logic [RES_W-1:0] w_sum;
    logic [RES_W-1:0] w_diff;
    logic [RES_W-1:0] w_add_res;
    logic [RES_W-1:0] w_sub_res;
    logic [WIDTH-1:0] w_logic;
    logic [RES_W-1:0] w_logic_ext;
    logic [RES_W-1:0] w_op_res;
    logic             w_op_err;

    assign w_op = opcode_e'(opcode);

    // ------------------------------------------------------------------
    // Combinational operation unit (non-MUL ops)
    // ------------------------------------------------------------------
    assign w_a_ext = {{(RES_W-WIDTH){A[WIDTH-1]}}, A};
    assign w_b_ext = {{(RES_W-WIDTH){B[WIDTH-1]}}, B};
    // RES_W >= WIDTH+1, so these are exact.
    assign w_sum   = w_a_ext + w_b_ext;
    assign w_diff  = w_a_ext - w_b_ext;

`ifdef ALU_SAT_EN
    logic [63:0] w_sum_sat;
    logic [63:0] w_diff_sat;
    assign w_sum_sat  = sat_w({{(64-RES_W){w_sum[RES_W-1]}}, w_sum}, WIDTH);
    assign w_diff_sat = sat_w({{(64-RES_W){w_diff[RES_W-1]}}, w_diff}, WIDTH);
    assign w_add_res  = w_sum_sat[RES_W-1:0];
    assign w_sub_res  = w_diff_sat[RES_W-1:0];
`else
    assign w_add_res  = w_sum;
    assign w_sub_res  = w_diff;
`endif

    always_comb begin
        w_logic = '0;
        case (w_op)
            OP_AND:  w_logic = A & B;
            OP_OR:   w_logic = A | B;
            OP_XOR:  w_logic = A ^ B;
            OP_NOT:  w_logic = ~A;
            default: w_logic = '0;
        endcase
    end

    assign w_logic_ext = {{(RES_W-WIDTH){w_logic[WIDTH-1]}}, w_logic};

    always_comb begin
        w_op_res = '0;
        w_op_err = 1'b0;
        case (w_op)
            OP_ADD:  w_op_res = w_add_res;
            OP_SUB:  w_op_res = w_sub_res;
            OP_AND,
            OP_OR,
            OP_XOR,
            OP_NOT:  w_op_res = w_logic_ext;
            OP_MUL:  w_op_res = '0;
            default: w_op_err = 1'b1;
        endcase
    end

    // ------------------------------------------------------------------
    // Multiplier
    // ------------------------------------------------------------------
    alu_mul_seq #(
        .WIDTH (WIDTH)
    ) u_mul (
        .clk       (clk),
        .rst       (rst),
        .i_en      (en),
        .i_start   (w_mul_start),
        .i_a       (A),
        .i_b       (B),
        .o_busy    (w_mul_busy),
        .o_done    (w_mul_done),
        .o_product (w_mul_product)
    );

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else if (en) begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = (w_op == OP_MUL) ? ST_MUL : ST_DONE;
                end
            end
            ST_MUL: begin
                // Busy is already low when done pulses; done is the trigger.
                if (w_mul_done && !w_mul_busy) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                if (w_accept) begin
                    w_state_nxt = (w_op == OP_MUL) ? ST_MUL : ST_DONE;
                end else if (out_ready) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        in_ready    = en & ((r_state == ST_IDLE) | ((r_state == ST_DONE) & out_ready));
        out_valid   = (r_state == ST_DONE);
        w_accept    = in_valid & in_ready;
        w_mul_start = w_accept & (w_op == OP_MUL);
    end

    // ------------------------------------------------------------------
    // Output register: written on a non-MUL accept or at multiply completion
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_c   <= '0;
            r_err <= 1'b0;
        end else if (en) begin
            if (w_accept && (w_op != OP_MUL)) begin
                r_c   <= w_op_res;
                r_err <= w_op_err;
            end else if ((r_state == ST_MUL) && w_mul_done) begin
                r_c   <= w_mul_product;
                r_err <= 1'b0;
            end
        end
    end

    assign C   = r_c;
    assign err = r_err;

endmodule
